// File: rtl/eq_out_fifo_if.sv
// Sample stream between the equalizer and downstream logic: push side plus FWFT pop side.
// Latency: none (wires only).
// Backpressure: in_valid has no ready (drops happen in the FIFO); out_valid/out_ready is a normal handshake.
// Ports: in_valid/in_data from the equalizer FIR, out_valid/out_ready/out_data toward the consumer.
// master = stream source and consumer (test side); slave = eq_out_fifo.
interface eq_out_fifo_if #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/eq_out_fifo.sv
// Equalizer output conditioner: round, saturate and queue samples in a small first-word-fall-through FIFO.
// Latency: 2 cycles from in_valid to out_valid (stage-1 register, then the FIFO write).
// Backpressure: none toward the filter; a full FIFO with no pop drops the sample and counts it.
// Ports: clk, rst_n (async, active-low), bus (slave modport: in_valid/in_data, out_valid/out_ready/out_data),
//        clr (sync clear of statistics only), level (occupancy), overflow (sticky drop flag),
//        drop_cnt / sat_cnt (16-bit saturating counters).
module eq_out_fifo #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    eq_out_fifo_if.slave             bus,
    input  logic                     clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic [15:0]              sat_cnt
);
    localparam int AW = $clog2(DEPTH);
    // Width wide enough to hold both the rounded value and the output clamp limits.
    localparam int EW = (IN_W + 1 > OUT_W) ? IN_W + 1 : OUT_W;

    // Half-LSB of the bits being discarded; zero when nothing is discarded.
    localparam logic signed [IN_W:0]  RND     = (IN_W+1)'((1 << SHIFT) >> 1);
    localparam logic signed [EW-1:0]  SAT_MAX = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EW-1:0]  SAT_MIN = ~SAT_MAX;
    localparam logic [AW:0]           FULL_LVL = (AW+1)'(DEPTH);

    // ---------------- stage 1: round + saturate ----------------
    logic signed [IN_W:0]    sum;
    logic signed [IN_W:0]    rnd;
    logic signed [EW-1:0]    rnd_ext;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [OUT_W-1:0] sat_val;

    always_comb begin
        sum     = '0;
        rnd     = '0;
        rnd_ext = '0;
        sat_hi  = 1'b0;
        sat_lo  = 1'b0;
        sat_val = '0;
        // One extra bit of headroom so adding the rounding constant cannot wrap.
        sum     = $signed({bus.in_data[IN_W-1], bus.in_data}) + RND;
        rnd     = sum >>> SHIFT;
        rnd_ext = EW'(rnd);
        sat_hi  = (rnd_ext > SAT_MAX);
        sat_lo  = (rnd_ext < SAT_MIN);
        if (sat_hi)
            sat_val = SAT_MAX[OUT_W-1:0];
        else if (sat_lo)
            sat_val = SAT_MIN[OUT_W-1:0];
        else
            sat_val = rnd_ext[OUT_W-1:0];
    end

    logic                    s1_valid;
    logic signed [OUT_W-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_data  <= sat_val;
        end
    end

    // ---------------- FIFO ----------------
    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             pop;
    logic             wr;
    logic             drop;

    assign full = (level == FULL_LVL);
    assign pop  = bus.out_valid && bus.out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr   = s1_valid && (!full || pop);
    assign drop = s1_valid && full && !pop;

    // Storage is not reset; out_valid gates its visibility.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= s1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // DEPTH is a power of two, so the natural AW-bit wrap gives DEPTH-1 -> 0.
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop)
                level <= level + (AW+1)'(1);
            else if (pop && !wr)
                level <= level - (AW+1)'(1);
        end
    end

    assign bus.out_valid = (level != '0);
    assign bus.out_data  = (level != '0) ? $signed(mem[rd_ptr]) : '0;

    // ---------------- statistics ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            sat_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.in_valid && (sat_hi || sat_lo) && (sat_cnt != 16'hFFFF))
                sat_cnt <= sat_cnt + 16'd1;
            if (drop && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
            if (drop)
                overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eq_out_fifo.sv
// Scoreboard bench for eq_out_fifo: directed samples push expected outputs, a monitor pops and compares.
// Latency: n/a.
// Backpressure: out_ready is driven per scenario to exercise fill, drop and drain.
module tb_eq_out_fifo;
    localparam int IN_W  = 17;
    localparam int OUT_W = 16;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [2:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic [15:0] sat_cnt;

    eq_out_fifo_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    eq_out_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(1), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clr      (clr),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .sat_cnt  (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every accepted head word is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %0d expected none", int'(bus.out_data));
            end else begin
                chk("out_data", int'(bus.out_data), exp_q.pop_front());
            end
        end
    end

    // One in_valid cycle; inputs change 1 time unit after the rising edge.
    task automatic send(input int d, input bit push, input int e);
        bus.in_valid = 1'b1;
        bus.in_data  = d[IN_W-1:0];
        if (push)
            exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while ((level != 0 || exp_q.size() != 0) && n < 50) begin
            step(1);
            n++;
        end
        step(1);
        chk({nm, "_drained"}, int'(n < 50), 1);
        chk({nm, "_level0"}, int'(level), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step(3);

        // Reset state
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        step(1);

        // Rounding, half toward +inf
        bus.out_ready = 1'b1;
        send(5, 1, 3);
        send(-5, 1, -2);
        send(4, 1, 2);
        drain("round");
        chk("round_sat_cnt", int'(sat_cnt), 0);

        // Saturation at both ends (only the positive one clamps)
        send(65535, 1, 32767);
        step(1);
        chk("sat_pos_cnt", int'(sat_cnt), 1);
        send(-65536, 1, -32768);
        drain("sat");
        chk("sat_neg_cnt", int'(sat_cnt), 1);

        // Overflow: six samples into a stalled 4-deep FIFO
        bus.out_ready = 1'b0;
        send(1, 1, 1);
        send(2, 1, 1);
        send(3, 1, 2);
        send(4, 1, 2);
        send(5, 0, 0);
        send(6, 0, 0);
        step(1);
        chk("ovf_level", int'(level), 4);
        chk("ovf_drop_cnt", int'(drop_cnt), 2);
        chk("ovf_flag", int'(overflow), 1);

        // clr coinciding with a dropping write wins over the increment
        send(7, 0, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_drop_cnt", int'(drop_cnt), 0);
        chk("clr_overflow", int'(overflow), 0);
        chk("clr_level", int'(level), 4);
        drain("ovf");

        // Full with simultaneous pop: level holds at 4, nothing dropped
        bus.out_ready = 1'b0;
        send(10, 1, 5);
        send(12, 1, 6);
        send(14, 1, 7);
        send(16, 1, 8);
        step(1);
        chk("full_fill_level", int'(level), 4);
        send(20, 1, 10);
        chk("full_pre_level", int'(level), 4);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 10; i++) begin
            send(20 + 2 * i, 1, 10 + i);
            chk("full_pop_level", int'(level), 4);
        end
        step(1);
        chk("full_last_level", int'(level), 4);
        chk("full_drop_cnt", int'(drop_cnt), 0);
        drain("full");

        // Reset mid-stream with three entries queued
        bus.out_ready = 1'b0;
        send(100, 0, 0);
        send(65535, 0, 0);
        send(2, 0, 0);
        step(1);
        chk("mid_level", int'(level), 3);
        chk("mid_sat_cnt", int'(sat_cnt), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_level", int'(level), 0);
        chk("mid_rst_sat_cnt", int'(sat_cnt), 0);
        chk("mid_rst_drop_cnt", int'(drop_cnt), 0);
        step(1);
        rst_n = 1'b1;
        exp_q.delete();
        step(1);

        // First sample after release: visible exactly two edges later
        bus.out_ready = 1'b1;
        send(8, 1, 4);
        chk("lat_edge1_valid", int'(bus.out_valid), 0);
        step(1);
        chk("lat_edge2_valid", int'(bus.out_valid), 1);
        chk("lat_edge2_data", int'(bus.out_data), 4);
        drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
